// File: rtl/alu_req_sequencer.sv
// Request/response sequencer for an external combinational ALU: accepts one request,
// issues it for a single cycle, captures the result and holds it until consumed.
module alu_req_sequencer #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [15:0]      op_count
);

   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_NE  = 3'b100;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t             r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_result;
   logic [TAG_W-1:0]   r_out_tag;
   logic               r_out_err;
   logic [15:0]        r_op_count;
   logic [WIDTH-1:0]   r_alu_a;
   logic [WIDTH-1:0]   r_alu_b;
   logic [2:0]         r_alu_opcode;
   logic               w_accept;

   function automatic logic is_legal(input logic [2:0] op);
      return (op == OP_XOR) || (op == OP_NE);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // in_ready decodes registered state only; rst masks it so nothing is taken during reset
   assign in_ready   = (r_state == IDLE) && !rst;
   assign w_accept   = in_valid && in_ready;

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_tag    = r_out_tag;
   assign out_err    = r_out_err;
   assign op_count   = r_op_count;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_opcode;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_tag    <= '0;
         r_out_err    <= 1'b0;
         r_op_count   <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_opcode <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_out_tag <= in_tag;
                  if (is_legal(in_opcode)) begin
                     // ALU operand registers change only on a legal issue
                     r_alu_a      <= in_a;
                     r_alu_b      <= in_b;
                     r_alu_opcode <= in_opcode;
                     r_out_err    <= 1'b0;
                     r_state      <= ISSUE;
                  end else begin
                     r_out_result <= '0;
                     r_out_err    <= 1'b1;
                     r_out_valid  <= 1'b1;
                     r_state      <= RESP;
                  end
               end
            end
            ISSUE: begin
               r_out_result <= alu_result;
               r_out_valid  <= 1'b1;
               r_state      <= RESP;
            end
            RESP: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
                  if (!r_out_err) r_op_count <= sat_inc(r_op_count);
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Bench for alu_req_sequencer: table of requests plus reset, backpressure and saturation sequences.
module tb_alu_req_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_opcode;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_tag;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_tag;
   logic        out_err;
   logic [15:0] op_count;

   always #5 clk = ~clk;

   // Reference combinational ALU attached to the sequencer
   assign alu_result = (alu_opcode == 3'b011) ? (alu_a ^ alu_b) :
                       (alu_opcode == 3'b100) ? {31'd0, (alu_a != alu_b)} : 32'hDEADBEEF;

   alu_req_sequencer #(.WIDTH(32), .TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_err(out_err), .op_count(op_count)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] exp_res;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        err;
   } sb_t;

   sb_t         sb_q[$];
   vec_t        vecs[10];
   int          n_checks = 0;
   int          n_err = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic [2:0]  exp_alu_op = 3'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic scramble_inputs();
      in_opcode = 3'($urandom);
      in_a      = $urandom;
      in_b      = $urandom;
      in_tag    = 4'($urandom);
   endtask

   // Drives one request, optionally stalls the response for 'stall' cycles, checks everything.
   task automatic run_req(input vec_t v, input int stall);
      int          waited;
      int          lat;
      logic [31:0] hold_res;
      logic [3:0]  hold_tag;
      sb_t         exp;
      @(negedge clk);
      in_valid  = 1'b1;
      in_opcode = v.op;
      in_a      = v.a;
      in_b      = v.b;
      in_tag    = v.tag;
      out_ready = 1'b0;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      sb_q.push_back('{v.exp_res, v.tag, v.exp_err});
      if (!v.exp_err) exp_alu_op = v.op;
      @(negedge clk);
      // Keep in_valid high with junk: must be ignored while busy
      scramble_inputs();
      if (!v.exp_err) begin
         chk("issue_alu_a", 64'(alu_a), 64'(v.a));
         chk("issue_alu_b", 64'(alu_b), 64'(v.b));
         chk("issue_alu_op", 64'(alu_opcode), 64'(v.op));
      end
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         scramble_inputs();
         lat++;
      end
      chk("latency", 64'(lat), v.exp_err ? 64'd1 : 64'd2);
      hold_res = out_result;
      hold_tag = out_tag;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         scramble_inputs();
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_result", 64'(out_result), 64'(hold_res));
         chk("stall_tag", 64'(out_tag), 64'(hold_tag));
         chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         exp = sb_q.pop_front();
         chk("out_valid", 64'(out_valid), 64'd1);
         chk("out_result", 64'(out_result), 64'(exp.res));
         chk("out_tag", 64'(out_tag), 64'(exp.tag));
         chk("out_err", 64'(out_err), 64'(exp.err));
         chk("resp_in_ready", 64'(in_ready), 64'd0);
         if (!exp.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("post_valid", 64'(out_valid), 64'd0);
      chk("post_in_ready", 64'(in_ready), 64'd1);
      chk("op_count", 64'(op_count), 64'(exp_cnt));
      chk("alu_op_hold", 64'(alu_opcode), 64'(exp_alu_op));
   endtask

   initial begin
      vecs[0] = '{3'b011, 32'hFFFF0000, 32'h0F0F0F0F, 4'd5,  32'hF0F00F0F, 1'b0};
      vecs[1] = '{3'b100, 32'h12345678, 32'h12345678, 4'd3,  32'h00000000, 1'b0};
      vecs[2] = '{3'b100, 32'h00000001, 32'h00000002, 4'd4,  32'h00000001, 1'b0};
      vecs[3] = '{3'b111, 32'hAAAA5555, 32'h00000001, 4'd9,  32'h00000000, 1'b1};
      vecs[4] = '{3'b000, 32'h11111111, 32'h22222222, 4'd2,  32'h00000000, 1'b1};
      vecs[5] = '{3'b011, 32'h00000000, 32'h00000000, 4'd15, 32'h00000000, 1'b0};
      vecs[6] = '{3'b011, 32'hFFFFFFFF, 32'h12345678, 4'd7,  32'hEDCBA987, 1'b0};
      vecs[7] = '{3'b101, 32'h0000FFFF, 32'hFFFF0000, 4'd1,  32'h00000000, 1'b1};
      vecs[8] = '{3'b100, 32'h80000000, 32'h00000000, 4'd0,  32'h00000001, 1'b0};
      vecs[9] = '{3'b010, 32'h00000003, 32'h00000005, 4'd6,  32'h00000000, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_opcode = 3'd0; in_a = '0; in_b = '0; in_tag = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 10; i++) begin
         run_req(vecs[i], (i == 6) ? 5 : (i % 2));
      end

      // Reset while a legal request is in ISSUE: request is dropped
      @(negedge clk);
      in_valid = 1'b1; in_opcode = 3'b011; in_a = 32'h5; in_b = 32'h3; in_tag = 4'd11;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_issue_valid", 64'(out_valid), 64'd0);
      chk("mid_issue_alu_a", 64'(alu_a), 64'h5);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_op_count", 64'(op_count), 64'd0);
      @(negedge clk);
      chk("midrst_hold_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      exp_cnt = 16'd0;
      exp_alu_op = 3'd0;
      run_req(vecs[0], 0);

      // Preload the counter near its ceiling, then confirm saturation
      @(negedge clk);
      force dut.r_op_count = 16'hFFFE;
      @(negedge clk);
      release dut.r_op_count;
      exp_cnt = 16'hFFFE;
      chk("preload", 64'(op_count), 64'hFFFE);
      run_req(vecs[6], 0);
      run_req(vecs[2], 0);
      run_req(vecs[3], 0);
      run_req(vecs[5], 1);
      chk("sat_final", 64'(op_count), 64'hFFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
